mem_port_sequencer: RTL

- Sequences and shares the single-port unified memory of the multi-cycle cpu between two requesters: instruction fetch (IF) and data load/store (DM).
- Sits between the cpu control/datapath and the memory.
- Arbitrates one request at a time, drives the memory port, waits the fixed memory latency, and returns read data with a one-cycle acknowledge pulse.

---
 rtl/mem_port_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_sequencer.sv
// Shares one single-port memory between instruction fetch (IF) and data (DM) requesters.
// Optional starvation guard for IF is enabled with `define ARB_STARVE_GUARD_EN.
module mem_port_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_sequencer: MEM_LAT must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_sequencer: STARVE_MAX must be in 1..15");
  end

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Handshake: a requester raises *_req with stable address/data and holds it
  // until its one-cycle *_ack; it drops *_req in the cycle after the ack unless
  // it already has a new request. Inputs are latched at grant time.
  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              busy_q, busy_d;
  logic              grant_dm, grant_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // IF wins once DM has been granted STARVE_MAX times in a row while IF waited.
  always_comb begin
    grant_dm = dm_req && !(if_req && (starve_cnt_q == STARVE_LIM));
    grant_if = if_req && !grant_dm;
  end
`else
  always_comb begin
    grant_dm = dm_req;
    grant_if = if_req && !dm_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
        if (!if_req)       starve_cnt_d = '0;
        else if (grant_dm) starve_cnt_d = starve_cnt_q + 4'd1;
        else               starve_cnt_d = '0;
`endif
        if (grant_dm) begin
          owner_d     = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_en_d    = 1'b1;
          state_d     = S_ISSUE;
        end else if (grant_if) begin
          owner_d     = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_en_d    = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          if (!mem_we_q) begin
            if (owner_q) dm_rdata_d = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          dm_ack_d = owner_q;
          if_ack_d = !owner_q;
          state_d  = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      busy_q      <= busy_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule
